// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: decode-stage issue scheduler for the 5-stage pipeline.
//
// Keeps a per-register countdown until an in-flight result becomes
// forwardable, and tracks the single shared long-latency unit (iterative
// divider): whether it is busy, and which destination it will write.
// Each cycle it decides whether the ID instruction issues or stalls.
//
// Optional build macro: SB_DONE_BYPASS_EN. When it is defined, the
// long-unit writeback cycle already counts as "result available" and
// "unit free" for hazard checks, so a waiting consumer or a new long op
// issues in that same cycle.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_valid                    ID holds a valid instruction
//   id_rs1/_used, id_rs2/_used  source registers and their use flags
//   id_rd, id_reg_write         destination register and write enable
//   id_lat                      cycles after issue before rd is forwardable
//   id_long                     instruction uses the long-latency unit
//   ex_flush                    branch redirect, kills the ID instruction
//   lu_done, lu_rd              long-unit writeback strobe and destination
//   stall, issue                ID held / ID advances this cycle
//   pc_en, if_id_en             front-end enables (~stall)
//   bubble_sel                  insert NOP into ID/EX
//   lu_busy                     long unit occupied
//   stall_cycles                saturating stall-cycle counter
module pipe_scoreboard #(
  parameter int LAT_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic             id_rs1_used,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             id_long,
  input  logic             ex_flush,
  input  logic             lu_done,
  input  logic [4:0]       lu_rd,
  output logic             stall,
  output logic             issue,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             bubble_sel,
  output logic             lu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // Entry 0 exists only to keep indexing uniform; it is held at zero so
  // x0 never produces a hazard.
  logic [LAT_W-1:0] cnt_q [32];
  logic [LAT_W-1:0] cnt_d [32];
  logic [31:0]      pend_q, pend_d, pend_eff;
  logic             lu_busy_q, lu_busy_d, busy_eff;
  logic [4:0]       lu_tag_q, lu_tag_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic done_ok;
  logic rs1_haz, rs2_haz, raw, waw, strct;

  // The writeback always retires the tracked tag; lu_rd is informational.
  logic unused_lu_rd;
  assign unused_lu_rd = ^lu_rd;

  // lu_done with an idle unit is a stray strobe and is ignored.
  assign done_ok = lu_done & lu_busy_q;

  always_comb begin
    pend_eff = pend_q;
    busy_eff = lu_busy_q;
`ifdef SB_DONE_BYPASS_EN
    if (done_ok) begin
      pend_eff[lu_tag_q] = 1'b0;
      busy_eff           = 1'b0;
    end
`endif
  end

  assign rs1_haz = id_rs1_used & (id_rs1 != 5'd0) &
                   ((cnt_q[id_rs1] != '0) | pend_eff[id_rs1]);
  assign rs2_haz = id_rs2_used & (id_rs2 != 5'd0) &
                   ((cnt_q[id_rs2] != '0) | pend_eff[id_rs2]);
  assign raw     = rs1_haz | rs2_haz;
  assign waw     = id_reg_write & (id_rd != 5'd0) & pend_eff[id_rd];
  assign strct   = id_long & busy_eff;

  // ex_flush kills the ID instruction, so it can neither stall nor issue.
  assign stall        = id_valid & ~ex_flush & (raw | waw | strct);
  assign issue        = id_valid & ~ex_flush & ~stall;
  assign pc_en        = ~stall;
  assign if_id_en     = ~stall;
  assign bubble_sel   = stall | ex_flush;
  assign lu_busy      = lu_busy_q;
  assign stall_cycles = stall_cnt_q;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : cnt_q[i];
    end
    if (issue & id_reg_write & (id_rd != 5'd0) & ~id_long) begin
      cnt_d[id_rd] = id_lat;
    end
    cnt_d[0] = '0;

    pend_d    = pend_q;
    lu_busy_d = lu_busy_q;
    lu_tag_d  = lu_tag_q;
    if (done_ok) begin
      lu_busy_d        = 1'b0;
      pend_d[lu_tag_q] = 1'b0;
    end
    // Applied after the clear so a same-cycle new long issue wins.
    if (issue & id_long) begin
      lu_busy_d = 1'b1;
      lu_tag_d  = id_rd;
      if (id_reg_write & (id_rd != 5'd0)) begin
        pend_d[id_rd] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;

    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      pend_q      <= '0;
      lu_busy_q   <= 1'b0;
      lu_tag_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pend_q      <= pend_d;
      lu_busy_q   <= lu_busy_d;
      lu_tag_q    <= lu_tag_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;
  localparam int LAT_W = 2;
  localparam int CNT_W = 16;
  localparam int unsigned SAT = (1 << CNT_W) - 1;
`ifdef SB_DONE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk, rst_n;
  logic             id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_long;
  logic [4:0]       id_rs1, id_rs2, id_rd, lu_rd;
  logic [LAT_W-1:0] id_lat;
  logic             ex_flush, lu_done;
  logic             stall, issue, pc_en, if_id_en, bubble_sel, lu_busy;
  logic [CNT_W-1:0] stall_cycles;

  pipe_scoreboard #(.LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_lat(id_lat), .id_long(id_long),
    .ex_flush(ex_flush), .lu_done(lu_done), .lu_rd(lu_rd),
    .stall(stall), .issue(issue), .pc_en(pc_en), .if_id_en(if_id_en),
    .bubble_sel(bubble_sel), .lu_busy(lu_busy), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: each register has the absolute cycle at which its
  // result becomes forwardable, plus a flag for "waiting on the divider".
  int unsigned cyc = 0;
  int unsigned ready_at [32];
  bit          waiting  [32];
  bit          m_busy;
  int          m_tag;
  int unsigned m_stalls;
  bit          s_stall, s_issue, s_pc_en, s_bubble;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ready_at[i] = 0;
      waiting[i]  = 1'b0;
    end
    m_busy   = 1'b0;
    m_tag    = 0;
    m_stalls = 0;
  endtask

  function automatic bit avail_wait(input int r, input bit dn);
    return waiting[r] && !(BYP && dn && m_busy && r == m_tag);
  endfunction

  function automatic bit src_hz(input bit used, input int r, input bit dn);
    return used && r != 0 && (cyc < ready_at[r] || avail_wait(r, dn));
  endfunction

  task automatic step(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                      input int rd, input bit rw, input int lat, input bit lng,
                      input bit fl, input bit dn, input int lrd);
    bit be, waw, st, ei;
    @(negedge clk);
    id_valid = v; id_rs1 = 5'(r1); id_rs1_used = u1; id_rs2 = 5'(r2); id_rs2_used = u2;
    id_rd = 5'(rd); id_reg_write = rw; id_lat = LAT_W'(lat); id_long = lng;
    ex_flush = fl; lu_done = dn; lu_rd = 5'(lrd);
    #1;
    be  = m_busy && !(BYP && dn);
    waw = rw && rd != 0 && avail_wait(rd, dn);
    st  = v && !fl && (src_hz(u1, r1, dn) || src_hz(u2, r2, dn) || waw || (lng && be));
    ei  = v && !fl && !st;
    chk("stall", 32'(stall), 32'(st));
    chk("issue", 32'(issue), 32'(ei));
    chk("pc_en", 32'(pc_en), 32'(!st));
    chk("if_id_en", 32'(if_id_en), 32'(!st));
    chk("bubble_sel", 32'(bubble_sel), 32'(st || fl));
    chk("lu_busy", 32'(lu_busy), 32'(m_busy));
    chk("stall_cycles", 32'(stall_cycles), m_stalls);
    s_stall = stall; s_issue = issue; s_pc_en = pc_en; s_bubble = bubble_sel;
    if (st && m_stalls < SAT) m_stalls++;
    if (dn && m_busy) begin
      m_busy = 1'b0;
      waiting[m_tag] = 1'b0;
    end
    if (ei && lng) begin
      m_busy = 1'b1;
      m_tag  = rd;
      if (rw && rd != 0) waiting[rd] = 1'b1;
    end
    if (ei && rw && rd != 0 && !lng) ready_at[rd] = cyc + 1 + lat;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    id_rd = 0; id_reg_write = 0; id_lat = 0; id_long = 0;
    ex_flush = 0; lu_done = 0; lu_rd = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_issue", 32'(issue), 0);
    chk("rst_pc_en", 32'(pc_en), 1);
    chk("rst_if_id_en", 32'(if_id_en), 1);
    chk("rst_bubble", 32'(bubble_sel), 0);
    chk("rst_lu_busy", 32'(lu_busy), 0);
    chk("rst_stall_cycles", 32'(stall_cycles), 0);
    rst_n = 1'b1;

    // Load-use: one stall cycle.
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    chk("lu_stall", 32'(s_stall), 1);
    chk("lu_pc_en", 32'(s_pc_en), 0);
    chk("lu_bubble", 32'(s_bubble), 1);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    chk("lu_issue", 32'(s_issue), 1);
    chk("lu_stall_cycles", 32'(stall_cycles), 1);

    // ALU producer and x0 never stall; rd=0 leaves no state.
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    step(1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 0, 0);
    chk("alu_issue", 32'(s_issue), 1);
    step(1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 1, 3, 1, 0, 0, 0);
    chk("x0_issue", 32'(s_issue), 1);
    step(1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 1, 0);

    // Divider to x9; consumer waits for lu_done at cycle 10.
    step(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step(1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
      chk("div_wait", 32'(s_stall), 1);
    end
    step(1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 1, 9);
    chk("div_done_cycle", 32'(s_issue), 32'(BYP));
    step(1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
    chk("div_after", 32'(s_issue), 1);

    // Structural and WAW stalls against a busy divider.
    step(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 10, 1, 0, 1, 0, 0, 0);
    chk("struct_stall", 32'(s_stall), 1);
    step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    chk("waw_stall", 32'(s_stall), 1);
    step(1, 0, 0, 0, 0, 10, 1, 0, 1, 0, 1, 9);
    chk("struct_done", 32'(s_issue), 32'(BYP));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10);
    idle();

    // Flush overrides a pending load-use stall; the counter keeps running.
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 5, 1, 6, 1, 0, 0, 1, 0, 0);
    chk("fl_stall", 32'(s_stall), 0);
    chk("fl_issue", 32'(s_issue), 0);
    chk("fl_bubble", 32'(s_bubble), 1);
    chk("fl_pc_en", 32'(s_pc_en), 1);
    step(1, 0, 0, 5, 1, 6, 1, 0, 0, 0, 0, 0);
    chk("fl_then_issue", 32'(s_issue), 1);

    // Randomized traffic on a small register window.
    for (int n = 0; n < 3000; n++) begin
      bit dn;
      int lrd;
      dn  = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      lrd = ($urandom_range(0, 4) != 0) ? m_tag : int'($urandom_range(0, 7));
      step($urandom_range(0, 19) != 0,
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, dn, lrd);
    end

    // Reset while a divider result is pending and a consumer is stalled.
    idle();
    step(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0);
    step(1, 9, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_stall", 32'(s_stall), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_lu_busy", 32'(lu_busy), 0);
    chk("mid_rst_stall_cycles", 32'(stall_cycles), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1, 9, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    chk("post_rst_issue", 32'(s_issue), 1);

    // Saturation of the stall counter.
    step(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0);
    for (int n = 0; n < int'(SAT) + 5; n++) begin
      step(1, 9, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    end
    @(posedge clk);
    #1;
    chk("sat_stall_cycles", 32'(stall_cycles), SAT);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
